// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared constants and tx state encoding for the spike packet path
package snn_pkg;
  localparam int NUM_NEURONS = 256;
  localparam int AXON_W      = 8;
  localparam int DELAY_W     = 4;
  localparam int PACKET_W    = AXON_W + DELAY_W;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SCAN = 2'd1,
    TX_SEND = 2'd2
  } tx_state_t;
endpackage

// File: rtl/spike_priority_encoder.sv
// rtl/spike_priority_encoder.sv - combinational lowest-set-bit finder over the pending spike vector
module spike_priority_encoder #(
  parameter int NUM_NEURONS = 256,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic [NUM_NEURONS-1:0] vec,
  output logic [IDX_W-1:0]       idx,
  output logic                   any_set
);

  // Scan downward so the last hit written is the lowest index.
  always_comb begin
    idx     = '0;
    any_set = 1'b0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx     = IDX_W'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_packet_tx.sv
// rtl/spike_packet_tx.sv - turns a tick's spike vector into ordered destination packets
module spike_packet_tx #(
  parameter int NUM_NEURONS = snn_pkg::NUM_NEURONS,
  parameter int AXON_W      = snn_pkg::AXON_W,
  parameter int DELAY_W     = snn_pkg::DELAY_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tick,
  input  logic [NUM_NEURONS-1:0]      spikes,
  input  logic                        cfg_wen,
  input  logic [7:0]                  cfg_addr,
  input  logic [AXON_W+DELAY_W:0]     cfg_data,
  output logic                        pkt_valid,
  input  logic                        pkt_ready,
  output logic [AXON_W+DELAY_W-1:0]   packet,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
);
  import snn_pkg::*;

  localparam int IDX_W   = $clog2(NUM_NEURONS);
  localparam int ENTRY_W = AXON_W + DELAY_W + 1;
  localparam int EN_BIT  = AXON_W + DELAY_W;

  tx_state_t state_q, state_d;

  logic [NUM_NEURONS-1:0] pending_q;
  logic [ENTRY_W-1:0]     dest_tbl [NUM_NEURONS];
  logic [ENTRY_W-1:0]     entry_q;
  logic [IDX_W-1:0]       sel_q;
  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_any;
  logic                   send_done;

  spike_priority_encoder #(
    .NUM_NEURONS(NUM_NEURONS),
    .IDX_W      (IDX_W)
  ) u_enc (
    .vec    (pending_q),
    .idx    (enc_idx),
    .any_set(enc_any)
  );

  // A disabled entry retires immediately; an enabled one waits for the handshake.
  assign send_done = (state_q == TX_SEND) && (!entry_q[EN_BIT] || pkt_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: if (tick) state_d = TX_SCAN;
      TX_SCAN: state_d = enc_any ? TX_SEND : TX_IDLE;
      TX_SEND: if (send_done) state_d = TX_SCAN;
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Table reads use the pre-write contents, so a same-cycle write shows old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      entry_q   <= '0;
      sel_q     <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) dest_tbl[i] <= '0;
    end else begin
      if (cfg_wen && (32'(cfg_addr) < NUM_NEURONS)) begin
        dest_tbl[IDX_W'(cfg_addr)] <= cfg_data;
      end
      case (state_q)
        TX_IDLE: if (tick) pending_q <= spikes;
        TX_SCAN: begin
          if (enc_any) begin
            sel_q   <= enc_idx;
            entry_q <= dest_tbl[enc_idx];
          end
        end
        TX_SEND: if (send_done) pending_q[sel_q] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign pkt_valid = (state_q == TX_SEND) && entry_q[EN_BIT];
  assign packet    = pkt_valid ? entry_q[EN_BIT-1:0] : '0;
  assign busy      = (state_q != TX_IDLE);
  assign done      = (state_q == TX_SCAN) && !enc_any;
  assign overflow  = tick && (state_q != TX_IDLE);

endmodule
